// File: rtl/unpooler_if.sv
// Streaming bus between the unpooler and its neighbours: pooled input side plus
// the expanded raster output side.
interface unpooler_if #(
   parameter int unsigned N = 8
);
   logic [N-1:0] data_in;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] data_out;
   logic         valid_op;
   logic         end_op;

   modport master (
      output data_in, in_valid,
      input  in_ready, data_out, valid_op, end_op
   );

   modport slave (
      input  data_in, in_valid,
      output in_ready, data_out, valid_op, end_op
   );
endinterface

// File: rtl/unpooler.sv
// Re-expands a raster stream of pooled values into an m x m map, either by
// nearest-neighbour replication or by zero insertion around the top-left pixel.
module unpooler #(
   parameter int unsigned m         = 12,
   parameter int unsigned p         = 3,
   parameter int unsigned N         = 8,
   parameter int unsigned ZERO_FILL = 0
) (
   input  logic       clk,
   input  logic       master_rst,
   input  logic       ce,
   unpooler_if.slave  bus
);
   localparam int unsigned W   = m / p;
   localparam int unsigned WIW = (W > 1) ? $clog2(W) : 1;
   localparam int unsigned CW  = (m > 1) ? $clog2(m) : 1;
   localparam int unsigned PW  = (p > 1) ? $clog2(p) : 1;

   localparam logic [WIW-1:0] W_LAST = WIW'(W - 1);
   localparam logic [CW-1:0]  M_LAST = CW'(m - 1);
   localparam logic [PW-1:0]  P_LAST = PW'(p - 1);

   localparam logic [0:0] LOAD = 1'b0;
   localparam logic [0:0] EMIT = 1'b1;

   logic [0:0]     state;
   logic [WIW-1:0] wr_idx;
   logic [CW-1:0]  col;
   logic [PW-1:0]  sub_col;
   logic [WIW-1:0] buf_idx;
   logic [PW-1:0]  rep;
   logic [WIW-1:0] prow;
   logic [N-1:0]   row_buf [W];
   logic [N-1:0]   pix;
   logic           xfer;

   assign bus.in_ready = ce && (state == LOAD);
   assign xfer         = bus.in_ready && bus.in_valid;

   // Row buffer carries no reset; its contents are always rewritten before use.
   always_ff @(posedge clk) begin
      if (xfer) begin
         row_buf[wr_idx] <= bus.data_in;
      end
   end

   always_comb begin
      pix = row_buf[buf_idx];
      if ((ZERO_FILL != 0) && ((rep != '0) || (sub_col != '0))) begin
         pix = '0;
      end
   end

   always_ff @(posedge clk or negedge master_rst) begin
      if (!master_rst) begin
         state        <= LOAD;
         wr_idx       <= '0;
         col          <= '0;
         sub_col      <= '0;
         buf_idx      <= '0;
         rep          <= '0;
         prow         <= '0;
         bus.data_out <= '0;
         bus.valid_op <= 1'b0;
         bus.end_op   <= 1'b0;
      end else begin
         bus.valid_op <= 1'b0;
         bus.end_op   <= 1'b0;
         if (ce) begin
            case (state)
               LOAD: begin
                  if (bus.in_valid) begin
                     if (wr_idx == W_LAST) begin
                        wr_idx <= '0;
                        state  <= EMIT;
                     end else begin
                        wr_idx <= wr_idx + 1'b1;
                     end
                  end
               end
               default: begin
                  bus.data_out <= pix;
                  bus.valid_op <= 1'b1;
                  // sub_col/buf_idx track col/p without a divider
                  if (sub_col == P_LAST) begin
                     sub_col <= '0;
                     buf_idx <= (col == M_LAST) ? '0 : buf_idx + 1'b1;
                  end else begin
                     sub_col <= sub_col + 1'b1;
                  end
                  if (col == M_LAST) begin
                     col <= '0;
                     if (rep == P_LAST) begin
                        rep   <= '0;
                        state <= LOAD;
                        if (prow == W_LAST) begin
                           prow       <= '0;
                           bus.end_op <= 1'b1;
                        end else begin
                           prow <= prow + 1'b1;
                        end
                     end else begin
                        rep <= rep + 1'b1;
                     end
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_unpooler.sv
// Scoreboard bench: a replicate instance and a zero-insert instance share one
// stimulus stream; expected pixels are queued per pooled row and popped by monitors.
module tb_unpooler;
   localparam int M  = 12;
   localparam int P  = 3;
   localparam int NB = 8;
   localparam int WD = M / P;

   typedef struct packed {
      logic [NB-1:0] d;
      logic          e;
   } exp_t;

   logic          clk = 1'b0;
   logic          master_rst = 1'b0;
   logic          ce = 1'b0;
   logic [NB-1:0] data_in = '0;
   logic          in_valid = 1'b0;

   exp_t q0[$];
   exp_t q1[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   outs0 = 0;
   int   outs1 = 0;
   bit   abort = 1'b0;

   always #5 clk = ~clk;

   unpooler_if #(.N(NB)) bus0 ();
   unpooler_if #(.N(NB)) bus1 ();

   assign bus0.data_in  = data_in;
   assign bus0.in_valid = in_valid;
   assign bus1.data_in  = data_in;
   assign bus1.in_valid = in_valid;

   unpooler #(.m(M), .p(P), .N(NB), .ZERO_FILL(0)) dut0 (
      .clk(clk), .master_rst(master_rst), .ce(ce), .bus(bus0.slave)
   );
   unpooler #(.m(M), .p(P), .N(NB), .ZERO_FILL(1)) dut1 (
      .clk(clk), .master_rst(master_rst), .ce(ce), .bus(bus1.slave)
   );

   task automatic chk(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
      end
   endtask

   // Expected pixels of one pooled row, for both expansion modes.
   task automatic push_row(input int v0, input int v1, input int v2, input int v3,
                           input bit last_row);
      int   v[4];
      exp_t e;
      v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
      for (int r = 0; r < P; r++) begin
         for (int c = 0; c < M; c++) begin
            e.e = last_row && (r == P - 1) && (c == M - 1);
            e.d = NB'(v[c / P]);
            q0.push_back(e);
            e.d = ((r == 0) && (c % P == 0)) ? NB'(v[c / P]) : '0;
            q1.push_back(e);
         end
      end
   endtask

   always @(negedge clk) begin
      if (master_rst && bus0.valid_op) begin
         exp_t e;
         outs0++;
         if (q0.size() == 0) chk("nn unexpected output", 1, 0);
         else begin
            e = q0.pop_front();
            chk("nn data_out", int'(bus0.data_out), int'(e.d));
            chk("nn end_op", int'(bus0.end_op), int'(e.e));
         end
      end else if (master_rst && bus0.end_op) begin
         chk("nn end_op without valid", 1, 0);
      end
   end

   always @(negedge clk) begin
      if (master_rst && bus1.valid_op) begin
         exp_t e;
         outs1++;
         if (q1.size() == 0) chk("zf unexpected output", 1, 0);
         else begin
            e = q1.pop_front();
            chk("zf data_out", int'(bus1.data_out), int'(e.d));
            chk("zf end_op", int'(bus1.end_op), int'(e.e));
         end
      end else if (master_rst && bus1.end_op) begin
         chk("zf end_op without valid", 1, 0);
      end
   end

   task automatic send_map(input int base, input bit toggle, input bit gap_chk);
      int row[4];
      int tmo;
      int gap;
      for (int r = 0; r < WD; r++) begin
         for (int i = 0; i < WD; i++) begin
            @(negedge clk);
            if (abort) return;
            if (toggle) begin
               in_valid = 1'b0;
               @(negedge clk);
               if (abort) return;
            end
            row[i]   = base + r * WD + i;
            data_in  = NB'(row[i]);
            in_valid = 1'b1;
            tmo = 0;
            while (!bus0.in_ready) begin
               @(negedge clk);
               if (abort) return;
               tmo++;
               if (tmo > 2000) begin
                  chk("in_ready timeout", 0, 1);
                  return;
               end
            end
            if (i == WD - 1) begin
               push_row(row[0], row[1], row[2], row[3], r == WD - 1);
               if (gap_chk) begin
                  @(posedge clk);
                  #1 in_valid = 1'b0;
                  gap = 0;
                  do begin
                     @(negedge clk);
                     if (!bus0.in_ready) gap++;
                  end while (!bus0.in_ready && gap < 200);
                  chk("in_ready low cycles", gap, P * M);
               end
            end
         end
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((q0.size() != 0 || q1.size() != 0) && t < 5000) begin
         @(negedge clk);
         t++;
      end
      chk("drain pending nn", q0.size(), 0);
      chk("drain pending zf", q1.size(), 0);
      repeat (4) @(negedge clk);
   endtask

   task automatic stall_at(input int n);
      int            t = 0;
      logic [NB-1:0] h0, h1;
      while (outs0 < n && t < 5000) begin
         @(negedge clk);
         #1 t++;
      end
      chk("stall reached output", outs0, n);
      ce = 1'b0;
      h0 = bus0.data_out;
      h1 = bus1.data_out;
      repeat (5) begin
         @(negedge clk);
         #1;
         chk("stall valid_op", int'(bus0.valid_op), 0);
         chk("stall nn hold", int'(bus0.data_out), int'(h0));
         chk("stall zf hold", int'(bus1.data_out), int'(h1));
      end
      ce = 1'b1;
   endtask

   task automatic reset_at(input int n);
      int t = 0;
      while (outs0 < n && t < 5000) begin
         @(negedge clk);
         #1 t++;
      end
      chk("reset reached output", outs0, n);
      abort      = 1'b1;
      master_rst = 1'b0;
      #1;
      chk("mid reset nn data_out", int'(bus0.data_out), 0);
      chk("mid reset nn valid_op", int'(bus0.valid_op), 0);
      chk("mid reset zf end_op", int'(bus1.end_op), 0);
      q0.delete();
      q1.delete();
      in_valid = 1'b0;
      @(negedge clk);
      #2 master_rst = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      master_rst = 1'b0;
      ce = 1'b1;
      #3;
      chk("reset data_out", int'(bus0.data_out), 0);
      chk("reset valid_op", int'(bus0.valid_op), 0);
      chk("reset end_op", int'(bus0.end_op), 0);
      #9 master_rst = 1'b1;
      #1 chk("in_ready after reset", int'(bus0.in_ready), 1);

      outs0 = 0; outs1 = 0;
      send_map(1, 1'b0, 1'b1);
      drain();
      chk("map1 nn count", outs0, M * M);
      chk("map1 zf count", outs1, M * M);

      outs0 = 0; outs1 = 0;
      send_map(1, 1'b1, 1'b0);
      drain();
      chk("map2 nn count", outs0, M * M);

      outs0 = 0; outs1 = 0;
      fork
         send_map(1, 1'b0, 1'b0);
         stall_at(20);
      join
      drain();
      chk("stall map nn count", outs0, M * M);
      chk("stall map zf count", outs1, M * M);

      outs0 = 0; outs1 = 0;
      fork
         send_map(1, 1'b0, 1'b0);
         reset_at(50);
      join
      abort = 1'b0;
      outs0 = 0; outs1 = 0;
      send_map(101, 1'b0, 1'b0);
      drain();
      chk("post reset nn count", outs0, M * M);
      chk("post reset zf count", outs1, M * M);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
